video_sync_prog: RTL and testbench

- Parametrised, register-programmable raster timing generator. Successor to the fixed 50/60 Hz TSConf sync block.
- All horizontal and vertical timing (totals, sync, active window, interrupt point, polarities) is loaded at run time through a small write port.
- Writes go to a staging bank and are transferred to the active bank atomically at frame wrap.
- Drives the video pipeline (counters, window flags, strobes) and the CPU frame/line interrupt.

---
 rtl/video_sync_prog.sv | 214 +++++++++++++++++++++
 tb/tb_video_sync_prog.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_prog.sv
// Register-programmable raster timing generator: line/frame counters, sync and active
// windows, line/frame strobes and a sticky CPU interrupt. New timing takes effect at frame wrap.
module video_sync_prog #(
    parameter int W          = 10,
    parameter int H_TOT_RST  = 448,
    parameter int HS_BEG_RST = 11,
    parameter int HS_END_RST = 43,
    parameter int HA_BEG_RST = 88,
    parameter int HA_END_RST = 448,
    parameter int V_TOT_RST  = 320,
    parameter int VS_BEG_RST = 8,
    parameter int VS_END_RST = 11,
    parameter int VA_BEG_RST = 32,
    parameter int VA_END_RST = 320
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         wr,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic         int_ack,
    output logic [W-1:0] hcnt,
    output logic [W-1:0] vcnt,
    output logic         hsync,
    output logic         vsync,
    output logic         csync,
    output logic         blank,
    output logic         h_act,
    output logic         v_act,
    output logic         line_start,
    output logic         frame_start,
    output logic         int_req,
    output logic         upd_pend,
    output logic [7:0]   frame_cnt
);
    // Timing bank layout matches the write-port register index; ctrl (index 12) is kept apart.
    localparam int NBANK    = 12;
    localparam int IX_HTOT  = 0;
    localparam int IX_HSB   = 1;
    localparam int IX_HSE   = 2;
    localparam int IX_HAB   = 3;
    localparam int IX_HAE   = 4;
    localparam int IX_VTOT  = 5;
    localparam int IX_VSB   = 6;
    localparam int IX_VSE   = 7;
    localparam int IX_VAB   = 8;
    localparam int IX_VAE   = 9;
    localparam int IX_INTH  = 10;
    localparam int IX_INTV  = 11;
    localparam int IX_CTRL  = 12;

    localparam logic [NBANK-1:0][W-1:0] BANK_RST = {
        W'(0),          W'(0),
        W'(VA_END_RST), W'(VA_BEG_RST), W'(VS_END_RST), W'(VS_BEG_RST), W'(V_TOT_RST),
        W'(HA_END_RST), W'(HA_BEG_RST), W'(HS_END_RST), W'(HS_BEG_RST), W'(H_TOT_RST)
    };

    logic [NBANK-1:0][W-1:0] stg_reg;
    logic [NBANK-1:0][W-1:0] act_reg;
    logic [2:0]              stg_ctrl_reg;
    logic [2:0]              act_ctrl_reg;
    logic [IX_CTRL:0]        wr_sel;
    logic                    wr_any;
    logic                    upd_pend_reg;

    logic [W-1:0] hcnt_reg;
    logic [W-1:0] vcnt_reg;
    logic         hsync_reg;
    logic         vsync_reg;
    logic         csync_reg;
    logic         blank_reg;
    logic         h_act_reg;
    logic         v_act_reg;
    logic         int_req_reg;
    logic [7:0]   frame_cnt_reg;

    logic [W-1:0] htot, hs_beg, hs_end, ha_beg, ha_end;
    logic [W-1:0] vtot, vs_beg, vs_end, va_beg, va_end;
    logic [W-1:0] int_h, int_v;
    logic         int_en, vpol, hpol;
    logic         h_last, v_last;
    logic         hs_win, vs_win, ha_win, va_win;
    logic         int_hit;

    // Half-open window [b, e); b > e wraps through zero, b == e is empty.
    function automatic logic in_win(input logic [W-1:0] x, input logic [W-1:0] b,
                                    input logic [W-1:0] e);
        logic r;
        r = 1'b0;
        if (b < e)
            r = (x >= b) && (x < e);
        else if (b > e)
            r = (x >= b) || (x < e);
        return r;
    endfunction

    for (genvar gi = 0; gi <= IX_CTRL; gi++) begin : g_wsel
        assign wr_sel[gi] = wr && (waddr == 4'(gi));
    end
    assign wr_any = |wr_sel;

    assign htot   = act_reg[IX_HTOT];
    assign hs_beg = act_reg[IX_HSB];
    assign hs_end = act_reg[IX_HSE];
    assign ha_beg = act_reg[IX_HAB];
    assign ha_end = act_reg[IX_HAE];
    assign vtot   = act_reg[IX_VTOT];
    assign vs_beg = act_reg[IX_VSB];
    assign vs_end = act_reg[IX_VSE];
    assign va_beg = act_reg[IX_VAB];
    assign va_end = act_reg[IX_VAE];
    assign int_h  = act_reg[IX_INTH];
    assign int_v  = act_reg[IX_INTV];
    assign int_en = act_ctrl_reg[2];
    assign vpol   = act_ctrl_reg[1];
    assign hpol   = act_ctrl_reg[0];

    // Modular compare: a total of 0 wraps at 2^W.
    assign h_last      = (hcnt_reg == htot - W'(1));
    assign v_last      = (vcnt_reg == vtot - W'(1));
    assign line_start  = ce && h_last;
    assign frame_start = line_start && v_last;

    assign hs_win  = in_win(hcnt_reg, hs_beg, hs_end);
    assign vs_win  = in_win(vcnt_reg, vs_beg, vs_end);
    assign ha_win  = in_win(hcnt_reg, ha_beg, ha_end);
    assign va_win  = in_win(vcnt_reg, va_beg, va_end);
    assign int_hit = ce && int_en && (hcnt_reg == int_h) && (vcnt_reg == int_v);

    // Transfer reads staging before this cycle's write lands, so a coincident write waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_reg      <= BANK_RST;
            act_reg      <= BANK_RST;
            stg_ctrl_reg <= 3'b000;
            act_ctrl_reg <= 3'b000;
            upd_pend_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                act_reg      <= stg_reg;
                act_ctrl_reg <= stg_ctrl_reg;
                upd_pend_reg <= 1'b0;
            end
            for (int i = 0; i < NBANK; i++) begin
                if (wr_sel[i])
                    stg_reg[i] <= wdata;
            end
            if (wr_sel[IX_CTRL])
                stg_ctrl_reg <= wdata[2:0];
            if (wr_any)
                upd_pend_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (ce) begin
            if (h_last) begin
                hcnt_reg <= '0;
                vcnt_reg <= v_last ? '0 : vcnt_reg + W'(1);
            end else begin
                hcnt_reg <= hcnt_reg + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg <= 1'b0;
            vsync_reg <= 1'b0;
            csync_reg <= 1'b1;
            blank_reg <= 1'b1;
            h_act_reg <= 1'b0;
            v_act_reg <= 1'b0;
        end else if (ce) begin
            hsync_reg <= hs_win ^ hpol;
            vsync_reg <= vs_win ^ vpol;
            csync_reg <= ~(hs_win ^ vs_win);
            blank_reg <= ~(ha_win && va_win);
            h_act_reg <= ha_win;
            v_act_reg <= va_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req_reg   <= 1'b0;
            frame_cnt_reg <= 8'd0;
        end else begin
            if (int_hit)
                int_req_reg <= 1'b1;
            else if (int_ack)
                int_req_reg <= 1'b0;
            if (frame_start)
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

    assign hcnt      = hcnt_reg;
    assign vcnt      = vcnt_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign csync     = csync_reg;
    assign blank     = blank_reg;
    assign h_act     = h_act_reg;
    assign v_act     = v_act_reg;
    assign int_req   = int_req_reg;
    assign upd_pend  = upd_pend_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_video_sync_prog.sv
// Bench for video_sync_prog: cycle scoreboard against a behavioural raster model plus
// table-driven timing vectors and hand-written corner sequences.
module tb_video_sync_prog;
    localparam int W    = 10;
    localparam int TH   = 48;
    localparam int THSB = 3;
    localparam int THSE = 7;
    localparam int THAB = 8;
    localparam int THAE = 48;
    localparam int TV   = 10;
    localparam int TVSB = 1;
    localparam int TVSE = 2;
    localparam int TVAB = 2;
    localparam int TVAE = 10;

    logic         clk = 1'b0;
    logic         rst_n, ce, wr, int_ack;
    logic [3:0]   waddr;
    logic [W-1:0] wdata;
    logic [W-1:0] hcnt, vcnt;
    logic         hsync, vsync, csync, blank, h_act, v_act;
    logic         line_start, frame_start, int_req, upd_pend;
    logic [7:0]   frame_cnt;

    video_sync_prog #(
        .W(W), .H_TOT_RST(TH), .HS_BEG_RST(THSB), .HS_END_RST(THSE),
        .HA_BEG_RST(THAB), .HA_END_RST(THAE), .V_TOT_RST(TV), .VS_BEG_RST(TVSB),
        .VS_END_RST(TVSE), .VA_BEG_RST(TVAB), .VA_END_RST(TVAE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .wr(wr), .waddr(waddr), .wdata(wdata),
        .int_ack(int_ack), .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync), .vsync(vsync),
        .csync(csync), .blank(blank), .h_act(h_act), .v_act(v_act),
        .line_start(line_start), .frame_start(frame_start), .int_req(int_req),
        .upd_pend(upd_pend), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs, vs, cs, bl, ha, va, ir, up;
        logic [7:0] fc;
        logic       ls, fs;
    } obs_t;

    typedef struct {
        logic [9:0] htot, hsb, hse, hab, hae;
        logic [2:0] ctrl;
        int         exp_hs;
        int         exp_ha;
    } vec_t;

    logic [9:0] m_act [13];
    logic [9:0] m_stg [13];
    logic [9:0] m_h, m_v;
    obs_t       m_out;
    obs_t       sb_q [$];
    obs_t       sc_exp, sc_act;

    function automatic logic [9:0] rst_bank(input int i);
        case (i)
            0:       return 10'(TH);
            1:       return 10'(THSB);
            2:       return 10'(THSE);
            3:       return 10'(THAB);
            4:       return 10'(THAE);
            5:       return 10'(TV);
            6:       return 10'(TVSB);
            7:       return 10'(TVSE);
            8:       return 10'(TVAB);
            9:       return 10'(TVAE);
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic win(input logic [9:0] x, input logic [9:0] b, input logic [9:0] e);
        if (b == e) return 1'b0;
        if (b < e) return (x >= b) && (x < e);
        return !((x >= e) && (x < b));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) begin
            m_act[i] = rst_bank(i);
            m_stg[i] = rst_bank(i);
        end
        m_h = 10'd0;
        m_v = 10'd0;
        m_out = '0;
        m_out.cs = 1'b1;
        m_out.bl = 1'b1;
        sb_q.delete();
    endtask

    task automatic model_step();
        logic [9:0] hl_val, vl_val;
        logic hl, vl, fs, hit, hsr, vsr;
        hl_val = m_act[0] - 10'd1;
        vl_val = m_act[5] - 10'd1;
        hl  = (m_h == hl_val);
        vl  = (m_v == vl_val);
        fs  = ce && hl && vl;
        hit = ce && m_act[12][2] && (m_h == m_act[10]) && (m_v == m_act[11]);
        if (ce) begin
            hsr = win(m_h, m_act[1], m_act[2]);
            vsr = win(m_v, m_act[6], m_act[7]);
            m_out.hs = hsr ^ m_act[12][0];
            m_out.vs = vsr ^ m_act[12][1];
            m_out.cs = !(hsr ^ vsr);
            m_out.ha = win(m_h, m_act[3], m_act[4]);
            m_out.va = win(m_v, m_act[8], m_act[9]);
            m_out.bl = !(m_out.ha && m_out.va);
            if (hl) begin
                m_h = 10'd0;
                m_v = vl ? 10'd0 : m_v + 10'd1;
            end else begin
                m_h = m_h + 10'd1;
            end
        end
        if (hit) m_out.ir = 1'b1;
        else if (int_ack) m_out.ir = 1'b0;
        if (fs) begin
            for (int i = 0; i < 13; i++) m_act[i] = m_stg[i];
            m_out.up = 1'b0;
            m_out.fc = m_out.fc + 8'd1;
        end
        if (wr && waddr <= 4'd12) begin
            m_stg[waddr] = (waddr == 4'd12) ? {7'd0, wdata[2:0]} : wdata;
            m_out.up = 1'b1;
        end
        m_out.h  = m_h;
        m_out.v  = m_v;
        m_out.ls = 1'b0;
        m_out.fs = 1'b0;
        sb_q.push_back(m_out);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Scoreboard: one expected snapshot per clock, compared away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && sb_q.size() > 0) begin
                sc_exp = sb_q.pop_front();
                sc_exp.ls = ce && (m_h == m_act[0] - 10'd1);
                sc_exp.fs = sc_exp.ls && (m_v == m_act[5] - 10'd1);
                sc_act = {hcnt, vcnt, hsync, vsync, csync, blank, h_act, v_act,
                          int_req, upd_pend, frame_cnt, line_start, frame_start};
                n_tests++;
                if (sc_act !== sc_exp) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got %h expected %h", $time, sc_act, sc_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, got);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hcnt"}, 32'(hcnt), 0);
        chk({tag, "_vcnt"}, 32'(vcnt), 0);
        chk({tag, "_hsync"}, 32'(hsync), 0);
        chk({tag, "_vsync"}, 32'(vsync), 0);
        chk({tag, "_csync"}, 32'(csync), 1);
        chk({tag, "_blank"}, 32'(blank), 1);
        chk({tag, "_h_act"}, 32'(h_act), 0);
        chk({tag, "_v_act"}, 32'(v_act), 0);
        chk({tag, "_int_req"}, 32'(int_req), 0);
        chk({tag, "_upd_pend"}, 32'(upd_pend), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic wreg(input logic [3:0] a, input logic [9:0] d);
        @(negedge clk); #1;
        wr = 1'b1; waddr = a; wdata = d;
        @(negedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk); #1 int_ack = 1'b1;
        @(negedge clk); #1 int_ack = 1'b0;
    endtask

    task automatic meas(input bit frame, output int n);
        n = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (frame ? frame_start : line_start) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL meas_timeout: no %s strobe within 3000 cycles", frame ? "frame" : "line");
        end
    endtask

    vec_t tbl [4];
    int   n, fc0, c_hs, c_ha, pos0, pos1, cur_htot, cur_vtot;
    bit   found;

    initial begin
        tbl[0] = '{10'd40, 10'd5,  10'd9, 10'd8,  10'd40, 3'b000, 4,  32};
        tbl[1] = '{10'd30, 10'd25, 10'd3, 10'd0,  10'd30, 3'b000, 8,  30};
        tbl[2] = '{10'd30, 10'd7,  10'd7, 10'd10, 10'd5,  3'b001, 30, 25};
        tbl[3] = '{10'd25, 10'd0,  10'd1, 10'd3,  10'd3,  3'b000, 1,  0};

        rst_n = 1'b0; ce = 1'b1; wr = 1'b0; waddr = 4'd0; wdata = '0; int_ack = 1'b0;
        #23;
        check_reset("por");
        @(negedge clk); #1 rst_n = 1'b1;

        // Default timing after reset.
        meas(0, n);
        meas(0, n); chk("rst_line_period", n, TH);
        meas(1, n); fc0 = int'(frame_cnt);
        meas(1, n); chk("rst_frame_period", n, TH * TV);
        chk("frame_cnt_inc", 32'(frame_cnt), fc0 + 1);

        // Mid-frame reprogramming waits for the frame wrap.
        repeat (100) @(negedge clk);
        wreg(4'd0, 10'd24);
        wreg(4'd5, 10'd5);
        @(negedge clk); chk("mid_upd_pend_set", 32'(upd_pend), 1);
        meas(0, n);
        meas(0, n); chk("mid_old_line_period", n, TH);
        meas(1, n);
        meas(0, n); chk("mid_new_line_period", n, 24);
        chk("mid_upd_pend_clr", 32'(upd_pend), 0);
        cur_htot = 24; cur_vtot = 5;
        meas(1, n);
        meas(1, n); chk("mid_new_frame_period", n, 24 * 5);

        // Table-driven horizontal window vectors.
        for (int r = 0; r < 4; r++) begin
            wreg(4'd0, tbl[r].htot);
            wreg(4'd1, tbl[r].hsb);
            wreg(4'd2, tbl[r].hse);
            wreg(4'd3, tbl[r].hab);
            wreg(4'd4, tbl[r].hae);
            wreg(4'd12, {7'd0, tbl[r].ctrl});
            @(negedge clk); chk($sformatf("vec%0d_upd_pend", r), 32'(upd_pend), 1);
            meas(1, n);
            meas(0, n); chk($sformatf("vec%0d_line_period", r), n, int'(tbl[r].htot));
            cur_htot = int'(tbl[r].htot);
            c_hs = 0; c_ha = 0;
            for (int k = 0; k < cur_htot; k++) begin
                @(negedge clk);
                c_hs += int'(hsync);
                c_ha += int'(h_act);
            end
            chk($sformatf("vec%0d_hsync_ticks", r), c_hs, tbl[r].exp_hs);
            chk($sformatf("vec%0d_h_act_ticks", r), c_ha, tbl[r].exp_ha);
        end

        // Write landing on the frame_start clock is deferred one frame.
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        chk("fs_align_found", 32'(found), 1);
        #1 wr = 1'b1; waddr = 4'd0; wdata = 10'd20;
        @(negedge clk); chk("fs_wr_upd_pend", 32'(upd_pend), 1);
        #1 wr = 1'b0;
        meas(0, n);
        meas(0, n); chk("fs_wr_old_period", n, 25);
        meas(1, n);
        meas(0, n); chk("fs_wr_new_period", n, 20);
        chk("fs_wr_upd_pend_clr", 32'(upd_pend), 0);
        cur_htot = 20;

        // Interrupt at (5,3) with both polarities inverted.
        wreg(4'd10, 10'd5);
        wreg(4'd11, 10'd3);
        wreg(4'd12, 10'd7);
        meas(1, n);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (int_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("int_fired", 32'(found), 1);
        chk("int_rise_hcnt", 32'(hcnt), 6);
        chk("int_rise_vcnt", 32'(vcnt), 3);
        repeat (10) @(negedge clk);
        chk("int_sticky", 32'(int_req), 1);
        @(negedge clk); #1 int_ack = 1'b1;
        @(negedge clk); chk("int_ack_clears", 32'(int_req), 0);
        #1 int_ack = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (hcnt == 10'd5 && vcnt == 10'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("int_align_found", 32'(found), 1);
        #1 int_ack = 1'b1;
        @(negedge clk); chk("int_set_beats_ack", 32'(int_req), 1);
        #1 int_ack = 1'b0;

        // Interrupt point beyond the line total never fires.
        wreg(4'd10, 10'd100);
        meas(1, n);
        ack_pulse();
        meas(1, n);
        chk("int_out_of_range", 32'(int_req), 0);

        // Half-rate ce: position advances once per enabled clock.
        @(negedge clk);
        pos0 = int'(vcnt) * cur_htot + int'(hcnt);
        #1 ce = 1'b0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk); #1 ce = (i % 2 == 1);
        end
        @(negedge clk);
        pos1 = int'(vcnt) * cur_htot + int'(hcnt);
        chk("ce_half_rate_pos", pos1, (pos0 + 20) % (cur_htot * cur_vtot));
        #1 ce = 1'b1;

        // Asynchronous reset mid-line, observed before any clock edge.
        wreg(4'd6, 10'd1);
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset("async");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        meas(0, n);
        meas(0, n); chk("post_rst_line_period", n, TH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
